// File: rtl/mean_window.sv
// mean_window: averages a stream of WIDTH-bit samples over a runtime
// selectable window of 2^L samples, either decimating (block mode, one
// result per window) or as a moving average (sliding mode, one result per
// sample once the window has filled).
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   i_cfg_load   one-cycle pulse: latch L/mode and clear datapath state
//   i_cfg_log2n  window exponent L (clamped to MAX_LOG2N)
//   i_cfg_mode   0 = block, 1 = sliding
//   i_vld        input sample valid
//   i_data       input sample
//   o_vld        one-cycle result strobe
//   o_data       rounded average, held between strobes
//   o_full       sliding mode: window holds 2^L samples (0 in block mode)
module mean_window #(
  parameter int WIDTH     = 32,
  parameter int MAX_LOG2N = 4,
  parameter int SIGNED    = 0,
  parameter int ROUND     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_cfg_load,
  input  logic [$clog2(MAX_LOG2N+1)-1:0]   i_cfg_log2n,
  input  logic                             i_cfg_mode,
  input  logic                             i_vld,
  input  logic [WIDTH-1:0]                 i_data,
  output logic                             o_vld,
  output logic [WIDTH-1:0]                 o_data,
  output logic                             o_full
);

  localparam int ACC_WIDTH = WIDTH + MAX_LOG2N;
  localparam int LW        = $clog2(MAX_LOG2N + 1);
  localparam int CW        = MAX_LOG2N + 1;
  localparam int PW        = MAX_LOG2N;
  localparam int DEPTH     = 1 << MAX_LOG2N;
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LOG2N);

  typedef enum logic {
    MODE_BLOCK   = 1'b0,
    MODE_SLIDING = 1'b1
  } mode_t;

  logic [LW-1:0]        log2n;
  mode_t                mode;
  logic [CW-1:0]        count;
  logic [ACC_WIDTH-1:0] acc;
  logic [PW-1:0]        wptr;
  logic [CW-1:0]        fill;
  logic [WIDTH-1:0]     ring [DEPTH];

  logic                 accepted;
  logic [CW-1:0]        win_size;
  logic [PW-1:0]        old_idx;
  logic [ACC_WIDTH-1:0] new_ext;
  logic [ACC_WIDTH-1:0] old_ext;
  logic                 window_full;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CW-1:0]        count_next;
  logic [CW-1:0]        fill_next;
  logic                 strobe;
  logic [ACC_WIDTH-1:0] rnd;
  logic [ACC_WIDTH-1:0] rounded;
  logic [WIDTH-1:0]     avg;
  logic [LW-1:0]        cfg_clamped;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) extend = {{MAX_LOG2N{v[WIDTH-1]}}, v};
    else             extend = {{MAX_LOG2N{1'b0}}, v};
  endfunction

  assign accepted    = i_vld & ~i_cfg_load;
  assign win_size    = CW'(1) << log2n;
  assign cfg_clamped = (i_cfg_log2n > MAX_L) ? MAX_L : i_cfg_log2n;

  // The leaving sample sits 2^L slots behind the write pointer; with the
  // largest window that is the slot about to be overwritten, which is why
  // the ring is read combinationally before the write lands.
  assign old_idx     = wptr - win_size[PW-1:0];
  assign new_ext     = extend(i_data);
  assign old_ext     = extend(ring[old_idx]);
  assign window_full = (fill == win_size);

  // Next-state of the accumulator and counters for an accepted sample, plus
  // the window sum that feeds the output divider.
  always_comb begin
    sum        = acc + new_ext;
    acc_next   = acc;
    count_next = count;
    fill_next  = fill;
    strobe     = 1'b0;
    if (mode == MODE_BLOCK) begin
      // The closing sample restarts the window so the next one is not lost.
      if (count + CW'(1) == win_size) begin
        strobe     = 1'b1;
        acc_next   = '0;
        count_next = '0;
      end else begin
        acc_next   = sum;
        count_next = count + CW'(1);
      end
    end else begin
      if (window_full) begin
        sum      = acc + new_ext - old_ext;
        acc_next = sum;
        strobe   = 1'b1;
      end else begin
        acc_next  = sum;
        fill_next = fill + CW'(1);
        strobe    = (fill + CW'(1) == win_size);
      end
    end
  end

  // Round-half-up then divide by 2^L; arithmetic shift keeps negative sums
  // rounding toward +infinity.
  always_comb begin
    rnd = '0;
    if (ROUND != 0 && log2n != '0) rnd = ACC_WIDTH'(1) << (log2n - LW'(1));
    rounded = sum + rnd;
    if (SIGNED != 0) avg = WIDTH'($signed(rounded) >>> log2n);
    else             avg = WIDTH'(rounded >> log2n);
  end

  // Control, accumulator and output registers. A config load takes priority
  // over a coincident sample, which is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log2n  <= MAX_L;
      mode   <= MODE_BLOCK;
      count  <= '0;
      acc    <= '0;
      wptr   <= '0;
      fill   <= '0;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_full <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      if (i_cfg_load) begin
        log2n  <= cfg_clamped;
        mode   <= mode_t'(i_cfg_mode);
        count  <= '0;
        acc    <= '0;
        wptr   <= '0;
        fill   <= '0;
        o_full <= 1'b0;
      end else if (i_vld) begin
        acc    <= acc_next;
        count  <= count_next;
        fill   <= fill_next;
        o_full <= (mode == MODE_SLIDING) && (fill_next == win_size);
        if (mode == MODE_SLIDING) wptr <= wptr + PW'(1);
        if (strobe) begin
          o_vld  <= 1'b1;
          o_data <= avg;
        end
      end
    end
  end

  // Sample history for the sliding window; contents are only read once
  // written since fill tracks how many slots are valid.
  always_ff @(posedge clk) begin
    if (accepted && mode == MODE_SLIDING) ring[wptr] <= i_data;
  end

endmodule

// File: doc/mean_window.md
Name: mean_window

Overview:
- Parametrised successor to the fixed power-of-two block averager in the postprocess chain. Sits after the FFT magnitude stage.
- Averages a stream of WIDTH-bit samples over a runtime-selectable window of 2^L samples.
- Two modes:
  - block (decimating): one output per window.
  - sliding (moving average): one output per sample once the window has filled.
- Supports signed data, round-half-up, and input gaps.

Parameters:
- WIDTH, 32: sample width.
- MAX_LOG2N, 4: largest window exponent. Ring buffer depth is 2^MAX_LOG2N.
- SIGNED, 0: 1 = two's-complement data and arithmetic shift; 0 = unsigned.
- ROUND, 1: 1 = add 2^(L-1) before the shift when L>0; 0 = truncate.
- Derived localparam ACC_WIDTH = WIDTH+MAX_LOG2N. This is wide enough that overflow cannot occur.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_cfg_load  in  1  one-cycle pulse; latches the config and clears datapath state.
- i_cfg_log2n  in  $clog2(MAX_LOG2N+1)  window exponent L. Values >MAX_LOG2N are clamped to MAX_LOG2N.
- i_cfg_mode  in  1  0 = block, 1 = sliding.
- i_vld  in  1  input sample valid.
- i_data  in  WIDTH  input sample.
- o_vld  out  1  one-cycle output strobe.
- o_data  out  WIDTH  average; holds its last value between strobes.
- o_full  out  1  sliding mode only: window has filled. Always 0 in block mode.

Behaviour:
- Reset (async, rst=1):
  - o_vld=0, o_data=0, o_full=0.
  - Sample counter, accumulator, ring write pointer and fill count cleared.
  - Config reset to L=MAX_LOG2N, mode=block.
  - Ring contents need not be cleared.
- Config load: on i_cfg_load=1 the clamped L and the mode are latched, and counter, accumulator, pointer, fill and o_full are cleared. o_vld is 0 the next cycle. If i_vld is also 1 in that cycle, load wins and the sample is dropped. Config changes only via load.
- Accepted sample: i_vld=1 and i_cfg_load=0. Cycles with i_vld=0 are ignored; gaps of any length do not disturb state.
- Block mode:
  - Each accepted sample updates acc <= acc + ext(i_data), where ext is sign- or zero-extended per SIGNED.
  - The counter increments on each accepted sample.
  - On the 2^L-th sample:
    - Next cycle, o_vld=1 and o_data = (acc_final + rnd) >> L, truncated to WIDTH.
    - acc_final already includes the current sample.
    - The shift is arithmetic when SIGNED=1.
  - In that same cycle acc and counter restart at 0, so the next sample begins a new window with no lost sample.
  - Latency: 1 cycle from the last sample.
- Sliding mode:
  - Every accepted sample is written to ring[wptr], and wptr increments modulo 2^MAX_LOG2N.
  - While fill < 2^L: acc += new; fill increments.
  - Once fill == 2^L:
    - acc += new − ring[wptr − 2^L], the sample leaving the window, read combinationally before the write.
  - o_full=1 from the cycle after the 2^L-th accepted sample.
  - o_vld pulses the cycle after every accepted sample once the window holds 2^L samples, including the filling sample itself.
  - Output formula is the same as block mode.
- L=0: o_data = i_data, o_vld follows every accepted sample, 1-cycle latency, both modes.
- Rounding: rnd = ROUND && L>0 ? 2^(L−1) : 0. Round-half-up toward +∞ (−2.5 → −2).
- Outside strobes, o_vld=0 and o_data is unchanged.

Test Plan:
- Block, L=2, unsigned, ROUND=1: samples 1,2,3,4 → o_vld one cycle after the 4th, o_data=3 (10/4=2.5→3). Samples 5,5,5,5 next → o_data=5; exactly 2 strobes total.
- Block, L=2, with 0–3 idle cycles randomly inserted between samples 1,2,3,4 → identical o_data=3, single strobe, timing relative to the 4th sample.
- Sliding, L=2: samples 4,8,12,16,20,24 → no strobe for the first 3. Strobes after the 4th/5th/6th with o_data=10,14,18. o_full rises after the 4th.
- SIGNED=1, block L=2: −1,−2,−3,−4 → o_data=−2 (0x…FFFE). ROUND=0 variant → −3.
- Config: 3 samples in block L=2, then i_cfg_load with L=7 (MAX_LOG2N=4) → no strobe, L clamps to 4. Next 16 samples of value 7 → one strobe, o_data=7. Load coincident with i_vld → that sample is absent from the sum.
- Reset: assert rst asynchronously mid-window in sliding mode → outputs clear immediately. After release the window refills from empty; the first strobe comes after 2^L new samples.
